// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared FSM state type and default sizing for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  localparam int DEF_N_IRQ           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/irq_channel.sv
// rtl/irq_channel.sv - per-line synchroniser, debouncer and rising-edge detector
module irq_channel
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // The level only flips after the synced input has disagreed with it on
  // DEBOUNCE_CYCLES+1 consecutive edges; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      level_q <= level;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - N-channel masked, prioritised interrupt controller with req/ack/done handshake
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ           = DEF_N_IRQ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ID_W            = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             start,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] pending,
  output logic             iled
);

  irq_state_e       state, state_nxt;
  logic [N_IRQ-1:0] rise_vec;
  logic [N_IRQ-1:0] req_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  id_nxt;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
    irq_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst_n(start),
      .raw  (irq_in[i]),
      .rise (rise_vec[i])
    );
  end

  assign req_vec = pending & irq_en;

  // Descending scan so the lowest set index is the last assignment.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          state_nxt = REQ;
          id_nxt    = win_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt = SVC;
          clr_vec   = N_IRQ'(1) << irq_id;
        end
      end
      SVC: begin
        if (irq_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh edge in the ack cycle outranks the clear so it is not lost.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state   <= IDLE;
      irq_id  <= '0;
      pending <= '0;
      irq_req <= 1'b0;
      iled    <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_id  <= id_nxt;
      pending <= (pending & ~clr_vec) | rise_vec;
      irq_req <= (state_nxt == REQ);
      iled    <= (state_nxt == SVC);
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller with a behavioural reference model
module tb_irq_controller;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         start;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_en;
  logic         irq_ack;
  logic         irq_done;
  logic         irq_req;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;
  logic         iled;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 requesting, 2 in service
  int           m_state;
  logic [1:0]   m_id;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_deb;
  logic [7:0]   m_hist [N];

  irq_controller #(.N_IRQ(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .start(start), .irq_in(irq_in), .irq_en(irq_en),
    .irq_ack(irq_ack), .irq_done(irq_done), .irq_req(irq_req),
    .irq_id(irq_id), .pending(pending), .iled(iled)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_id    = '0;
    m_pend  = '0;
    m_rise  = '0;
    m_deb   = '0;
    for (int i = 0; i < N; i++) m_hist[i] = '0;
  endfunction

  // One clock edge; m_hist[i][j] is the raw sample taken j edges ago.
  function automatic void model_step();
    logic [N-1:0] clr;
    logic         flip;
    if (!start) begin
      model_reset();
      return;
    end
    clr = '0;
    case (m_state)
      0: if ((m_pend & irq_en) != 0) begin m_state = 1; m_id = lowest(m_pend & irq_en); end
      1: if (irq_ack) begin m_state = 2; clr[m_id] = 1'b1; end
      default: if (irq_done) m_state = 0;
    endcase
    m_pend = (m_pend & ~clr) | m_rise;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = {m_hist[i][6:0], irq_in[i]};
      flip = 1'b1;
      for (int j = 2; j <= 2 + D; j++) if (m_hist[i][j] == m_deb[i]) flip = 1'b0;
      m_rise[i] = flip && !m_deb[i];
      if (flip) m_deb[i] = ~m_deb[i];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; irq_in = '0; irq_en = 4'hF; irq_ack = 1'b0; irq_done = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({irq_req, iled, irq_id, pending} !== 8'h00) begin
      errors++; $display("FAIL reset_state got %0h want 0", {irq_req, iled, irq_id, pending});
    end
    start = 1'b1;
    repeat (3) tick();
    checks++;
    if ({irq_req, iled, pending} !== 6'h00) begin
      errors++; $display("FAIL reset_release got %0h want 0", {irq_req, iled, pending});
    end
  endtask

  task automatic test_single();
    irq_en = 4'hF; irq_in = 4'b0100;
    repeat (7) tick();
    checks++;
    if (pending !== 4'b0000) begin errors++; $display("FAIL single_pend_early got %b want 0000", pending); end
    tick();
    checks++;
    if (pending !== 4'b0100 || irq_req !== 1'b0) begin
      errors++; $display("FAIL single_pend got %b req %b want 0100 req 0", pending, irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
      errors++; $display("FAIL single_req got req %b id %0d want req 1 id 2", irq_req, irq_id);
    end
    pulse_ack();
    checks++;
    if (irq_req !== 1'b0 || iled !== 1'b1 || pending !== 4'b0000) begin
      errors++; $display("FAIL single_ack got req %b iled %b pend %b want 0 1 0000", irq_req, iled, pending);
    end
    irq_in = '0;
    pulse_done();
    tick();
    checks++;
    if (iled !== 1'b0 || irq_req !== 1'b0) begin
      errors++; $display("FAIL single_done got iled %b req %b want 0 0", iled, irq_req);
    end
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    int len;
    for (int n = 0; n < 4; n++) begin
      len = (n == 0) ? 3 : int'($urandom_range(1, D));
      irq_in[1] = 1'b1;
      repeat (len) tick();
      irq_in[1] = 1'b0;
      repeat (12) tick();
      checks++;
      if (pending !== 4'b0000 || irq_req !== 1'b0) begin
        errors++; $display("FAIL bounce_len%0d got pend %b req %b want 0000 0", len, pending, irq_req);
      end
    end
    irq_in[1] = 1'b1;
    repeat (10) tick();
    irq_in[1] = 1'b0;
    repeat (12) tick();
    checks++;
    if (pending !== 4'b0010 || irq_req !== 1'b1 || irq_id !== 2'd1) begin
      errors++; $display("FAIL bounce_held got pend %b req %b id %0d want 0010 1 1", pending, irq_req, irq_id);
    end
    pulse_ack(); pulse_done(); repeat (3) tick();
  endtask

  task automatic test_priority_stray();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if ({irq_req, iled, pending} !== 6'h00) begin
      errors++; $display("FAIL stray_ack got %0h want 0", {irq_req, iled, pending});
    end
    irq_en = 4'b1101; irq_in = 4'b1010;
    repeat (9) tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1010) begin
      errors++; $display("FAIL prio_mask got req %b id %0d pend %b want 1 3 1010", irq_req, irq_id, pending);
    end
    irq_en = 4'hF; tick();
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd3 || iled !== 1'b0) begin
      errors++; $display("FAIL prio_frozen got req %b id %0d iled %b want 1 3 0", irq_req, irq_id, iled);
    end
    irq_in = '0;
    pulse_ack();
    checks++;
    if (pending !== 4'b0010 || iled !== 1'b1) begin
      errors++; $display("FAIL prio_ack got pend %b iled %b want 0010 1", pending, iled);
    end
    pulse_done();
    checks++;
    if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_idle_gap got req %b want 0", irq_req); end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
      errors++; $display("FAIL prio_next got req %b id %0d want 1 1", irq_req, irq_id);
    end
    pulse_ack(); pulse_done(); repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    irq_in = 4'b0100;
    repeat (9) tick();
    irq_in = '0;
    repeat (10) tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0100) begin
      errors++; $display("FAIL simul_req got req %b id %0d pend %b want 1 2 0100", irq_req, irq_id, pending);
    end
    irq_in = 4'b0100;
    repeat (7) tick();
    pulse_ack();
    checks++;
    if (pending !== 4'b0100 || iled !== 1'b1 || irq_req !== 1'b0) begin
      errors++; $display("FAIL simul_set_wins got pend %b iled %b req %b want 0100 1 0", pending, iled, irq_req);
    end
    pulse_done();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 2'd2) begin
      errors++; $display("FAIL simul_rereq got req %b id %0d want 1 2", irq_req, irq_id);
    end
    irq_in = '0;
    pulse_ack(); pulse_done(); repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    irq_in = 4'b1001;
    repeat (9) tick();
    pulse_ack();
    checks++;
    if (iled !== 1'b1 || pending !== 4'b1000) begin
      errors++; $display("FAIL midrst_svc got iled %b pend %b want 1 1000", iled, pending);
    end
    irq_in = '0;
    start = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({irq_req, iled, pending} !== 6'h00) begin
      errors++; $display("FAIL midrst_async got %0h want 0", {irq_req, iled, pending});
    end
    repeat (2) tick();
    start = 1'b1;
    repeat (20) tick();
    checks++;
    if (irq_req !== 1'b0 || pending !== 4'b0000) begin
      errors++; $display("FAIL midrst_quiet got req %b pend %b want 0 0000", irq_req, pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
      irq_ack  = ($urandom_range(0, 3) == 0);
      irq_done = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (irq_req !== (m_state == 1) || iled !== (m_state == 2) || irq_id !== m_id || pending !== m_pend) begin
        errors++;
        $display("FAIL random_c%0d got req %b iled %b id %0d pend %b want %b %b %0d %b", c,
                 irq_req, iled, irq_id, pending, m_state == 1, m_state == 2, m_id, m_pend);
      end
    end
    irq_ack = 1'b0; irq_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_priority_stray();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
